// File: rtl/ram_burst_controller_if.sv
// Bundle of CPU-side and RAM-side signals for ram_burst_controller.
//  CPU side : read, write, address, datain -> controller; dataout, done, busy <- controller
//  RAM side : ramdatain -> controller; ramdataout, ramdata_oe, bank, bankgroup,
//             addressram, active, cs1, refresh <- controller
//  master   : the agent driving requests and RAM read data (CPU / test bench)
//  slave    : the controller itself
interface ram_burst_controller_if #(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned BEAT_W = 8,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned ROW_W  = 18
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] datain;
  logic [WORD_W-1:0] dataout;
  logic              done;
  logic              busy;
  logic [BEAT_W-1:0] ramdatain;
  logic [BEAT_W-1:0] ramdataout;
  logic              ramdata_oe;
  logic [1:0]        bank;
  logic [1:0]        bankgroup;
  logic [ROW_W-1:0]  addressram;
  logic              active;
  logic              cs1;
  logic              refresh;

  modport master (
    output read, write, address, datain, ramdatain,
    input  dataout, done, busy, ramdataout, ramdata_oe, bank, bankgroup, addressram,
    input  active, cs1, refresh
  );

  modport slave (
    input  read, write, address, datain, ramdatain,
    output dataout, done, busy, ramdataout, ramdata_oe, bank, bankgroup, addressram,
    output active, cs1, refresh
  );
endinterface

// File: rtl/ram_burst_controller.sv
// CPU-to-RAM burst bridge. Takes one WORD_W-bit read or write, issues ACTIVATE, waits TRCD
// cycles, issues a column command with auto-precharge, then moves WORD_W/BEAT_W beats LSB
// first. A free-running counter raises a refresh request every REF_INT clocks; it is serviced
// at the next IDLE and takes priority over CPU requests.
// Ports:
//  i_clock   : clock, rising edge
//  i_resetin : asynchronous active-low reset
//  io_bus    : ram_burst_controller_if.slave (CPU request/response and RAM pins)
module ram_burst_controller #(
  parameter int unsigned WORD_W  = 64,
  parameter int unsigned BEAT_W  = 8,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned ROW_W   = 18,
  parameter int unsigned COL_W   = 10,
  parameter int unsigned TRCD    = 1,
  parameter int unsigned REF_INT = 1024,
  parameter int unsigned REF_CYC = 4
) (
  input logic                     i_clock,
  input logic                     i_resetin,
  ram_burst_controller_if.slave   io_bus
);

  localparam int unsigned BEATS   = WORD_W / BEAT_W;
  localparam int unsigned CNT_MAX = (BEATS > TRCD) ? ((BEATS > REF_CYC) ? BEATS : REF_CYC)
                                                   : ((TRCD > REF_CYC) ? TRCD : REF_CYC);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned REF_W   = (REF_INT > 1) ? $clog2(REF_INT) : 1;
  localparam int unsigned ROW_LSB = ADDR_W - 4 - ROW_W;

  typedef enum logic [2:0] {
    StIdle,
    StAct,
    StWait,
    StCmd,
    StXfer,
    StDone,
    StRef
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;

  logic [REF_W-1:0]   r_ref_cnt;
  logic               r_ref_pending;
  logic               w_ref_wrap;

  logic               r_is_read;
  logic [1:0]         r_bank;
  logic [1:0]         r_grp;
  logic [ROW_W-1:0]   r_row;
  logic [COL_W-1:0]   r_col;
  logic [WORD_W-1:0]  r_wdata;
  logic [WORD_W-1:0]  r_shadow;
  logic [WORD_W-1:0]  r_dataout;

  logic               w_accept;
  logic               w_last_beat;
  int unsigned        w_beat_lsb;
  logic [WORD_W-1:0]  w_shadow_next;
  logic [ROW_W-1:0]   w_cmd_word;
  logic               w_unused;

  // Only the bank/group/row/column fields of the address are used.
  assign w_unused = ^io_bus.address;

  assign w_accept    = (r_state == StIdle) && !r_ref_pending && (io_bus.read || io_bus.write);
  assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));
  assign w_beat_lsb  = 32'(r_cnt) * BEAT_W;
  assign w_ref_wrap  = (r_ref_cnt == REF_W'(REF_INT - 1));

  // ---------------------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_resetin) begin
    if (!i_resetin) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Next-state logic; r_cnt is reused as wait, beat and refresh-hold counter
  // ---------------------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        w_cnt_next = '0;
        if (r_ref_pending) begin
          w_state_next = StRef;
        end else if (io_bus.read || io_bus.write) begin
          w_state_next = StAct;
        end
      end
      StAct: begin
        w_state_next = StWait;
        w_cnt_next   = '0;
      end
      StWait: begin
        if (r_cnt == CNT_W'(TRCD - 1)) begin
          w_state_next = StCmd;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      StCmd: begin
        w_state_next = StXfer;
        w_cnt_next   = '0;
      end
      StXfer: begin
        if (w_last_beat) begin
          w_state_next = StDone;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      StRef: begin
        if (r_cnt == CNT_W'(REF_CYC - 1)) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------
  // Refresh interval counter. A wrap on the same edge as REF entry re-arms the request.
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge i_clock or negedge i_resetin) begin
    if (!i_resetin) begin
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else begin
      r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + REF_W'(1);
      if (w_ref_wrap) begin
        r_ref_pending <= 1'b1;
      end else if (r_state == StIdle && r_ref_pending) begin
        r_ref_pending <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Request latch and read assembly
  // ---------------------------------------------------------------------------------------
  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[w_beat_lsb +: BEAT_W] = io_bus.ramdatain;
  end

  always_ff @(posedge i_clock or negedge i_resetin) begin
    if (!i_resetin) begin
      r_is_read <= 1'b0;
      r_bank    <= '0;
      r_grp     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_wdata   <= '0;
      r_shadow  <= '0;
      r_dataout <= '0;
    end else begin
      if (w_accept) begin
        // Read wins when both are requested; the write is dropped.
        r_is_read <= io_bus.read;
        r_bank    <= io_bus.address[ADDR_W-1 -: 2];
        r_grp     <= io_bus.address[ADDR_W-3 -: 2];
        r_row     <= io_bus.address[ROW_LSB +: ROW_W];
        r_col     <= io_bus.address[COL_W-1:0];
        r_wdata   <= io_bus.datain;
      end
      if (r_state == StXfer && r_is_read) begin
        r_shadow <= w_shadow_next;
        // Publish on the final beat so dataout is already valid while done is high.
        if (w_last_beat) begin
          r_dataout <= w_shadow_next;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Column command word: auto-precharge on bit 10, read/write on bit 14
  // ---------------------------------------------------------------------------------------
  always_comb begin
    w_cmd_word             = '0;
    w_cmd_word[16]         = 1'b1;
    w_cmd_word[15]         = 1'b0;
    w_cmd_word[14]         = r_is_read;
    w_cmd_word[12]         = 1'b0;
    w_cmd_word[10]         = 1'b1;
    w_cmd_word[COL_W-1:0]  = r_col;
  end

  // ---------------------------------------------------------------------------------------
  // Outputs, decoded from state only
  // ---------------------------------------------------------------------------------------
  always_comb begin
    io_bus.cs1        = 1'b1;
    io_bus.active     = 1'b0;
    io_bus.refresh    = 1'b0;
    io_bus.done       = 1'b0;
    io_bus.busy       = (r_state != StIdle);
    io_bus.ramdata_oe = 1'b0;
    io_bus.ramdataout = '0;
    io_bus.bank       = '0;
    io_bus.bankgroup  = '0;
    io_bus.addressram = '0;
    io_bus.dataout    = r_dataout;
    unique case (r_state)
      StIdle: begin
      end
      StAct: begin
        io_bus.cs1        = 1'b0;
        io_bus.active     = 1'b1;
        io_bus.bank       = r_bank;
        io_bus.bankgroup  = r_grp;
        io_bus.addressram = r_row;
      end
      StWait: begin
      end
      StCmd: begin
        io_bus.cs1        = 1'b0;
        io_bus.bank       = r_bank;
        io_bus.bankgroup  = r_grp;
        io_bus.addressram = w_cmd_word;
      end
      StXfer: begin
        io_bus.cs1 = 1'b0;
        if (!r_is_read) begin
          io_bus.ramdata_oe = 1'b1;
          io_bus.ramdataout = r_wdata[w_beat_lsb +: BEAT_W];
        end
      end
      StDone: begin
        io_bus.done = 1'b1;
      end
      StRef: begin
        io_bus.cs1     = 1'b0;
        io_bus.refresh = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ram_burst_controller.sv
// Self-checking bench for ram_burst_controller: reset state, a table of directed
// transactions, refresh deferral, asynchronous abort, a narrow/slow build and random traffic
// checked cycle by cycle against a transaction-level model.
module tb_ram_burst_controller;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned BEAT_W  = 8;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned ROW_W   = 18;
  localparam int unsigned COL_W   = 10;
  localparam int unsigned TRCD    = 1;
  localparam int unsigned REF_INT = 1024;
  localparam int unsigned REF_CYC = 4;
  localparam int unsigned BEATS   = WORD_W / BEAT_W;

  logic clock   = 1'b0;
  logic resetin = 1'b0;
  always #5 clock = ~clock;

  ram_burst_controller_if #(.WORD_W(WORD_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W))
    bus ();
  ram_burst_controller_if #(.WORD_W(32), .BEAT_W(8), .ADDR_W(64), .ROW_W(18)) bus_b ();

  ram_burst_controller #(
    .WORD_W(WORD_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W),
    .TRCD(TRCD), .REF_INT(REF_INT), .REF_CYC(REF_CYC)
  ) dut (
    .i_clock   (clock),
    .i_resetin (resetin),
    .io_bus    (bus)
  );

  ram_burst_controller #(
    .WORD_W(32), .BEAT_W(8), .ADDR_W(64), .ROW_W(18), .COL_W(10),
    .TRCD(3), .REF_INT(1024), .REF_CYC(4)
  ) dut_b (
    .i_clock   (clock),
    .i_resetin (resetin),
    .io_bus    (bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Clock edges seen since reset release; refresh requests fall on multiples of REF_INT.
  int unsigned n_edges;
  always @(posedge clock or negedge resetin) begin
    if (!resetin) n_edges <= 0;
    else          n_edges <= n_edges + 1;
  end

  int unsigned       last_ref_edge = 1;
  logic [WORD_W-1:0] m_dataout     = '0;

  typedef struct {
    logic              cs1, active, refresh, done, busy, oe, chk_cs;
    logic [1:0]        bank, grp;
    logic [ROW_W-1:0]  ar;
    logic [BEAT_W-1:0] rdo;
    logic [WORD_W-1:0] dout;
  } exp_t;

  typedef struct {
    logic              rd, wr;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] din, rword, exp_dout;
    string             nm;
  } vec_t;

  // A refresh is owed if some REF_INT boundary lies at or after the last REF entry edge.
  function automatic bit ref_due();
    int unsigned w;
    w = (n_edges / REF_INT) * REF_INT;
    return (n_edges >= REF_INT) && (w >= last_ref_edge);
  endfunction

  function automatic exp_t mk(input logic cs1, input logic act, input logic rf, input logic dn,
                              input logic bsy, input logic oe, input logic [1:0] bk,
                              input logic [1:0] gp, input logic [ROW_W-1:0] ar,
                              input logic [BEAT_W-1:0] rdo);
    exp_t e;
    e.cs1 = cs1; e.active = act; e.refresh = rf; e.done = dn; e.busy = bsy; e.oe = oe;
    e.chk_cs = 1'b1; e.bank = bk; e.grp = gp; e.ar = ar; e.rdo = rdo; e.dout = m_dataout;
    return e;
  endfunction

  function automatic exp_t idle_exp();
    return mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, '0, '0);
  endfunction

  task automatic chk(input exp_t e, input string nm);
    logic ok;
    ok = (bus.active === e.active) && (bus.refresh === e.refresh) && (bus.done === e.done) &&
         (bus.busy === e.busy) && (bus.ramdata_oe === e.oe) && (bus.bank === e.bank) &&
         (bus.bankgroup === e.grp) && (bus.addressram === e.ar) &&
         (bus.ramdataout === e.rdo) && (bus.dataout === e.dout) &&
         (!e.chk_cs || bus.cs1 === e.cs1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s t=%0t got cs1=%b act=%b ref=%b done=%b busy=%b oe=%b bank=%h grp=%h ar=%h rdo=%h dout=%h | want cs1=%b act=%b ref=%b done=%b busy=%b oe=%b bank=%h grp=%h ar=%h rdo=%h dout=%h",
               nm, $time, bus.cs1, bus.active, bus.refresh, bus.done, bus.busy, bus.ramdata_oe,
               bus.bank, bus.bankgroup, bus.addressram, bus.ramdataout, bus.dataout,
               e.cs1, e.active, e.refresh, e.done, e.busy, e.oe, e.bank, e.grp, e.ar, e.rdo,
               e.dout);
    end
  endtask

  task automatic chk_val(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  // Called at the negedge of an IDLE cycle with a refresh owed; returns at the next IDLE.
  task automatic run_ref();
    last_ref_edge = n_edges + 1;
    for (int i = 0; i < REF_CYC; i++) begin
      @(negedge clock);
      chk(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, '0, '0), "refresh");
    end
    @(negedge clock);
  endtask

  task automatic idle_step(output bit did_ref);
    chk(idle_exp(), "idle");
    did_ref = ref_due();
    if (did_ref) run_ref();
    else @(negedge clock);
  endtask

  // Full transaction with the CPU holding its request until done; starts and ends at the
  // negedge of an IDLE cycle.
  task automatic do_txn(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [WORD_W-1:0] din, input logic [WORD_W-1:0] rword,
                        output int n_ref);
    logic              is_rd;
    logic [1:0]        bk, gp;
    logic [ROW_W-1:0]  row, cmd;
    logic [BEAT_W-1:0] beat;
    exp_t              e;
    is_rd = rd;
    bk  = addr[ADDR_W-1 -: 2];
    gp  = addr[ADDR_W-3 -: 2];
    row = addr[ADDR_W-5 -: ROW_W];
    cmd = '0;
    cmd[16] = 1'b1;
    cmd[14] = is_rd;
    cmd[10] = 1'b1;
    cmd[COL_W-1:0] = addr[COL_W-1:0];
    bus.read = rd; bus.write = wr; bus.address = addr; bus.datain = din;
    n_ref = 0;
    forever begin
      chk(idle_exp(), "idle_req");
      if (!ref_due()) break;
      run_ref();
      n_ref++;
    end
    @(negedge clock);
    chk(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, bk, gp, row, '0), "act");
    for (int i = 0; i < TRCD; i++) begin
      @(negedge clock);
      e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, '0, '0);
      e.chk_cs = 1'b0;
      chk(e, "wait");
    end
    @(negedge clock);
    chk(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, bk, gp, cmd, '0), "cmd");
    for (int i = 0; i < BEATS; i++) begin
      @(negedge clock);
      if (is_rd) begin
        bus.ramdatain = rword[i*BEAT_W +: BEAT_W];
        beat = '0;
      end else begin
        bus.ramdatain = BEAT_W'($urandom);
        beat = din[i*BEAT_W +: BEAT_W];
      end
      chk(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, !is_rd, 2'b00, 2'b00, '0, beat), "xfer");
    end
    @(negedge clock);
    if (is_rd) m_dataout = rword;
    chk(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, '0, '0), "done");
    bus.read = 1'b0; bus.write = 1'b0; bus.ramdatain = '0;
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vt[4];
    int          n_ref, cyc, nb, ref_total, target;
    bit          did;
    logic [31:0] got;
    logic [63:0] base_addr;

    base_addr = {2'd2, 2'd1, 18'h15A5A, 32'h0, 10'h005};
    vt[0] = '{1'b0, 1'b1, base_addr, 64'h0807060504030201, 64'h0, 64'h0, "write"};
    vt[1] = '{1'b1, 1'b0, base_addr, 64'h0, 64'h8877665544332211, 64'h8877665544332211,
              "read"};
    vt[2] = '{1'b1, 1'b1, {2'd3, 2'd2, 18'h3FFFF, 32'hFFFF_FFFF, 10'h3FF},
              64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, "rd_and_wr"};
    vt[3] = '{1'b0, 1'b1, {2'd0, 2'd3, 18'h00001, 32'h0, 10'h200}, 64'hFFFF_0000_A5A5_5A5A,
              64'h0, 64'h0123456789ABCDEF, "write_keeps_dout"};

    bus.read = 0; bus.write = 0; bus.address = '0; bus.datain = '0; bus.ramdatain = '0;
    bus_b.read = 0; bus_b.write = 0; bus_b.address = '0; bus_b.datain = '0;
    bus_b.ramdatain = '0;

    // Reset state
    repeat (3) @(negedge clock);
    chk(idle_exp(), "reset_state");
    chk_val("reset_cs1", 64'(bus.cs1), 64'h1);
    chk_val("b_reset_state", {bus_b.cs1, bus_b.busy, bus_b.done, bus_b.dataout},
            {1'b1, 1'b0, 1'b0, 32'h0});
    resetin = 1'b1;
    @(negedge clock);

    // Narrow build: 32-bit word, TRCD=3 -> 4 beats, done at cycle 10
    bus_b.address = {2'd1, 2'd3, 18'h00ABC, 32'h0, 10'h3FF};
    bus_b.datain  = 32'hDDCCBBAA;
    bus_b.write   = 1'b1;
    cyc = 0; nb = 0; got = '0;
    while (bus_b.done !== 1'b1 && cyc < 50) begin
      if (bus_b.ramdata_oe === 1'b1) begin
        if (nb < 4) got[nb*8 +: 8] = bus_b.ramdataout;
        nb++;
      end
      @(negedge clock);
      cyc++;
    end
    bus_b.write = 1'b0;
    chk_val("b_write_latency", 64'(cyc), 64'd10);
    chk_val("b_write_beats", 64'(nb), 64'd4);
    chk_val("b_write_data", 64'(got), 64'hDDCCBBAA);
    @(negedge clock);
    bus_b.read = 1'b1;
    cyc = 0;
    while (bus_b.done !== 1'b1 && cyc < 50) begin
      bus_b.ramdatain = 8'(8'h10 + cyc);
      @(negedge clock);
      cyc++;
    end
    bus_b.read = 1'b0;
    chk_val("b_read_latency", 64'(cyc), 64'd10);
    chk_val("b_read_data", 64'(bus_b.dataout), 64'h19181716);
    @(negedge clock);

    // Directed table
    for (int i = 0; i < 4; i++) begin
      do_txn(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].din, vt[i].rword, n_ref);
      chk_val({"tbl_dout_", vt[i].nm}, bus.dataout, vt[i].exp_dout);
    end

    // Refresh boundary lands on the edge ending beat 1 of a write
    target = int'((n_edges / REF_INT + 1) * REF_INT) - 6;
    if (target <= int'(n_edges) + 16) target += REF_INT;
    while (int'(n_edges) < target) idle_step(did);
    chk_val("align_edges", 64'(n_edges), 64'(target));
    do_txn(1'b0, 1'b1, base_addr, 64'h1122334455667788, 64'h0, n_ref);
    chk_val("no_ref_before_write", 64'(n_ref), 64'd0);
    do_txn(1'b1, 1'b0, base_addr, 64'h0, 64'hCAFEBABE12345678, n_ref);
    chk_val("ref_deferred_to_idle", 64'(n_ref), 64'd1);
    chk_val("read_after_ref", bus.dataout, 64'hCAFEBABE12345678);

    // Asynchronous reset during beat 3 of a read
    bus.address = base_addr; bus.read = 1'b1; bus.write = 1'b0;
    chk(idle_exp(), "abort_idle");
    for (int i = 0; i < 3 + TRCD + 3; i++) @(negedge clock);
    chk_val("abort_busy_beat3", {bus.busy, bus.cs1}, {1'b1, 1'b0});
    #2 resetin = 1'b0;
    #1;
    m_dataout = '0;
    chk(idle_exp(), "abort_async");
    bus.read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk(idle_exp(), "abort_no_done");
    end
    resetin = 1'b1;
    last_ref_edge = 1;
    @(negedge clock);
    do_txn(1'b1, 1'b0, base_addr, 64'h0, 64'h0F1E2D3C4B5A6978, n_ref);
    chk_val("read_after_abort", bus.dataout, 64'h0F1E2D3C4B5A6978);

    // Random traffic against the model
    ref_total = 0;
    for (int t = 0; t < 300; t++) begin
      int unsigned op, gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < int'(gap); g++) begin
        idle_step(did);
        if (did) ref_total++;
      end
      op = $urandom_range(1, 3);
      do_txn(op[0], op[1], {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             n_ref);
      ref_total += n_ref;
    end
    chk_val("random_saw_refresh", 64'(ref_total > 0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
